// File: rtl/uart_pkg.sv
// Shared types and constants for the UART modem/flow-control slice.
// msr_t is the 16550 modem status register layout. modem_t holds the
// four modem status lines. delta_t holds the matching sticky change flags.
package uart_pkg;

    // Bit positions inside msr_o.
    localparam int MSR_DCTS = 0;
    localparam int MSR_DDSR = 1;
    localparam int MSR_TERI = 2;
    localparam int MSR_DDCD = 3;
    localparam int MSR_CTS  = 4;
    localparam int MSR_DSR  = 5;
    localparam int MSR_RI   = 6;
    localparam int MSR_DCD  = 7;

    typedef struct packed {
        logic dcd;
        logic ri;
        logic dsr;
        logic cts;
    } modem_t;

    typedef struct packed {
        logic ddcd;
        logic teri;
        logic ddsr;
        logic dcts;
    } delta_t;

    typedef struct packed {
        logic dcd;
        logic ri;
        logic dsr;
        logic cts;
        logic ddcd;
        logic teri;
        logic ddsr;
        logic dcts;
    } msr_t;

    // Width needed to hold a FIFO level from 0 to depth inclusive.
    function automatic int lvl_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/uart_flow_ctrl_if.sv
// CSR-side bundle of the flow-control unit: control bits and watermarks
// written by the CSR block, the MSR read strobe, and MSR/IRQ read back.
//   master : CSR block (drives cr_*, msr_rd; observes msr, msr_irq)
//   slave  : uart_flow_ctrl
interface uart_flow_ctrl_if #(
    parameter int LVL_W = 6
);
    logic             cr_uarten;
    logic             cr_rxe;
    logic             cr_txe;
    logic             cr_ctsen;
    logic             cr_rtsen;
    logic             cr_rts;
    logic             cr_dtr;
    logic             cr_out1;
    logic             cr_out2;
    logic             cr_lbe;
    logic             cr_msien;
    logic [LVL_W-1:0] cr_rxwm_hi;
    logic [LVL_W-1:0] cr_rxwm_lo;
    logic             msr_rd;
    logic [7:0]       msr;
    logic             msr_irq;

    modport master (
        output cr_uarten, cr_rxe, cr_txe, cr_ctsen, cr_rtsen,
        output cr_rts, cr_dtr, cr_out1, cr_out2, cr_lbe, cr_msien,
        output cr_rxwm_hi, cr_rxwm_lo, msr_rd,
        input  msr, msr_irq
    );

    modport slave (
        input  cr_uarten, cr_rxe, cr_txe, cr_ctsen, cr_rtsen,
        input  cr_rts, cr_dtr, cr_out1, cr_out2, cr_lbe, cr_msien,
        input  cr_rxwm_hi, cr_rxwm_lo, msr_rd,
        output msr, msr_irq
    );

endinterface

// File: rtl/uart_sync.sv
// 1-bit multi-flop synchroniser for an asynchronous input.
//   clk_i   : destination clock
//   rst_ni  : asynchronous active-low reset, loads RST_VAL into every stage
//   d_i     : asynchronous input
//   q_o     : synchronised output, STAGES cycles after d_i
module uart_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    // NOTE: the reset value is the idle level of the line, so nothing
    // downstream sees a phantom edge when reset releases.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= {STAGES{RST_VAL}};
        end else begin
            // NOTE: non-blocking so every stage samples its predecessor's old value.
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_flow_ctrl.sv
// Modem / flow-control unit between the CSR block and the RX/TX engines.
// Synchronises the modem inputs, keeps the 16550-style MSR with sticky
// deltas and the modem-status IRQ, drives auto-RTS from the RX FIFO level
// with hi/lo hysteresis, gates TX on CTS at frame boundaries, and routes
// the software modem outputs back to status in loopback.
//   clk_i, rst_ni              : clock, asynchronous active-low reset
//   csr                        : CSR bundle (control, watermarks, msr_rd, msr, msr_irq)
//   rx_fifo_level_i            : RX FIFO occupancy
//   tx_busy_i                  : TX engine is between start and stop bit
//   uart_{ri,cts,dsr,dcd}_ni   : asynchronous modem inputs, active-low
//   uart_{dtr,rts,out1,out2}_no: modem outputs, active-low, registered
//   uart_rx_en_o, uart_tx_en_o : engine enables, registered
module uart_flow_ctrl
    import uart_pkg::*;
#(
    parameter int  FIFO_DEPTH  = 32,
    parameter int  SYNC_STAGES = 2,
    localparam int LVL_W       = lvl_width(FIFO_DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    uart_flow_ctrl_if.slave  csr,
    input  logic [LVL_W-1:0] rx_fifo_level_i,
    input  logic             tx_busy_i,
    input  logic             uart_ri_ni,
    input  logic             uart_cts_ni,
    input  logic             uart_dsr_ni,
    input  logic             uart_dcd_ni,
    output logic             uart_dtr_no,
    output logic             uart_rts_no,
    output logic             uart_out1_no,
    output logic             uart_out2_no,
    output logic             uart_rx_en_o,
    output logic             uart_tx_en_o
);

    // Synchronised pins, still active-low.
    logic ri_sync_n, cts_sync_n, dsr_sync_n, dcd_sync_n;

    uart_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ri (
        .clk_i(clk_i), .rst_ni(rst_ni), .d_i(uart_ri_ni),  .q_o(ri_sync_n)
    );
    uart_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cts (
        .clk_i(clk_i), .rst_ni(rst_ni), .d_i(uart_cts_ni), .q_o(cts_sync_n)
    );
    uart_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_dsr (
        .clk_i(clk_i), .rst_ni(rst_ni), .d_i(uart_dsr_ni), .q_o(dsr_sync_n)
    );
    uart_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_dcd (
        .clk_i(clk_i), .rst_ni(rst_ni), .d_i(uart_dcd_ni), .q_o(dcd_sync_n)
    );

    modem_t status_d, status_q;
    delta_t delta_set, delta_d, delta_q;
    logic   rts_hold_d, rts_hold_q;
    logic   tx_en_d;
    msr_t   msr;

    // Status source: loopback feeds the software outputs straight back,
    // otherwise the inverted synchronised pins.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        status_d = modem_t'(~{dcd_sync_n, ri_sync_n, dsr_sync_n, cts_sync_n});
        if (csr.cr_lbe) begin
            status_d = '{dcd: csr.cr_out2, ri: csr.cr_out1, dsr: csr.cr_dtr, cts: csr.cr_rts};
        end
    end

    // Deltas: any change of cts/dsr/dcd, trailing edge only for ri.
    // A read clears the sticky bits but a change in the same cycle survives.
    always_comb begin
        delta_set.dcts = status_q.cts ^ status_d.cts;
        delta_set.ddsr = status_q.dsr ^ status_d.dsr;
        delta_set.ddcd = status_q.dcd ^ status_d.dcd;
        delta_set.teri = status_q.ri & ~status_d.ri;
        delta_d        = csr.msr_rd ? delta_set : delta_t'(delta_q | delta_set);
    end

    // Auto-RTS hysteresis; set wins, so hi <= lo behaves as a plain threshold.
    always_comb begin
        rts_hold_d = rts_hold_q;
        if (!csr.cr_rtsen) begin
            rts_hold_d = 1'b0;
        end else if (rx_fifo_level_i >= csr.cr_rxwm_hi) begin
            rts_hold_d = 1'b1;
        end else if (rx_fifo_level_i <= csr.cr_rxwm_lo) begin
            rts_hold_d = 1'b0;
        end
    end

    // CTS loss only blocks the start of a new frame, never one in flight.
    assign tx_en_d = csr.cr_uarten & csr.cr_txe
                   & (~csr.cr_ctsen | status_q.cts | tx_busy_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            status_q     <= '0;
            delta_q      <= '0;
            rts_hold_q   <= 1'b0;
            uart_dtr_no  <= 1'b1;
            uart_rts_no  <= 1'b1;
            uart_out1_no <= 1'b1;
            uart_out2_no <= 1'b1;
            uart_rx_en_o <= 1'b0;
            uart_tx_en_o <= 1'b0;
        end else begin
            status_q     <= status_d;
            delta_q      <= delta_d;
            rts_hold_q   <= rts_hold_d;
            // Loopback parks every modem pin at its inactive level.
            uart_dtr_no  <= csr.cr_lbe | ~csr.cr_dtr;
            uart_rts_no  <= csr.cr_lbe | ~(csr.cr_rts & ~rts_hold_d);
            uart_out1_no <= csr.cr_lbe | ~csr.cr_out1;
            uart_out2_no <= csr.cr_lbe | ~csr.cr_out2;
            uart_rx_en_o <= csr.cr_uarten & csr.cr_rxe;
            uart_tx_en_o <= tx_en_d;
        end
    end

    assign msr = '{dcd:  status_q.dcd, ri:   status_q.ri,
                   dsr:  status_q.dsr, cts:  status_q.cts,
                   ddcd: delta_q.ddcd, teri: delta_q.teri,
                   ddsr: delta_q.ddsr, dcts: delta_q.dcts};

    assign csr.msr     = msr;
    assign csr.msr_irq = csr.cr_msien & (|delta_q);

endmodule

// File: tb/tb_uart_flow_ctrl.sv
// Self-checking bench for uart_flow_ctrl: directed scenarios with literal
// expectations, then randomized stimulus compared every cycle against a
// behavioural model built from pin-history and the MSR/RTS/CTS rules.
module tb_uart_flow_ctrl;
    import uart_pkg::*;

    localparam int FIFO_DEPTH  = 32;
    localparam int SYNC_STAGES = 2;
    localparam int LVL_W       = $clog2(FIFO_DEPTH + 1);

    logic             clk;
    logic             rst_ni;
    logic [LVL_W-1:0] rx_fifo_level;
    logic             tx_busy;
    logic             ri_n, cts_n, dsr_n, dcd_n;
    logic             dtr_no, rts_no, out1_no, out2_no;
    logic             rx_en, tx_en;

    int n_checks = 0;
    int n_fail   = 0;

    uart_flow_ctrl_if #(.LVL_W(LVL_W)) csr_if ();

    uart_flow_ctrl #(.FIFO_DEPTH(FIFO_DEPTH), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
        .csr             (csr_if),
        .rx_fifo_level_i (rx_fifo_level),
        .tx_busy_i       (tx_busy),
        .uart_ri_ni      (ri_n),
        .uart_cts_ni     (cts_n),
        .uart_dsr_ni     (dsr_n),
        .uart_dcd_ni     (dcd_n),
        .uart_dtr_no     (dtr_no),
        .uart_rts_no     (rts_no),
        .uart_out1_no    (out1_no),
        .uart_out2_no    (out2_no),
        .uart_rx_en_o    (rx_en),
        .uart_tx_en_o    (tx_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Status nibble {dcd,ri,dsr,cts}; delta nibble {ddcd,teri,ddsr,dcts}.
    // Pin history: hist[j] is the pin vector sampled (j+1) edges ago.
    logic [3:0] hist [SYNC_STAGES];
    logic [3:0] m_st, m_dl, m_pins;
    logic       m_hold, m_rx_en, m_tx_en;

    always @(posedge clk) begin
        logic [3:0] old_st, new_st, set;
        if (!rst_ni) begin
            for (int i = 0; i < SYNC_STAGES; i++) hist[i] = 4'hF;
            m_st = '0; m_dl = '0; m_hold = 1'b0; m_pins = 4'hF;
            m_rx_en = 1'b0; m_tx_en = 1'b0;
        end else begin
            old_st = m_st;
            // A pin level reaches status SYNC_STAGES+1 edges after it was applied.
            if (csr_if.cr_lbe)
                new_st = {csr_if.cr_out2, csr_if.cr_out1, csr_if.cr_dtr, csr_if.cr_rts};
            else
                new_st = ~hist[SYNC_STAGES-1];
            for (int i = SYNC_STAGES - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = {dcd_n, ri_n, dsr_n, cts_n};
            set = {old_st[3] ^ new_st[3], old_st[2] & ~new_st[2],
                   old_st[1] ^ new_st[1], old_st[0] ^ new_st[0]};
            m_dl = csr_if.msr_rd ? set : (m_dl | set);
            m_st = new_st;
            m_tx_en = csr_if.cr_uarten & csr_if.cr_txe
                    & (~csr_if.cr_ctsen | old_st[0] | tx_busy);
            m_rx_en = csr_if.cr_uarten & csr_if.cr_rxe;
            if (!csr_if.cr_rtsen)                       m_hold = 1'b0;
            else if (rx_fifo_level >= csr_if.cr_rxwm_hi) m_hold = 1'b1;
            else if (rx_fifo_level <= csr_if.cr_rxwm_lo) m_hold = 1'b0;
            // {dtr, rts, out1, out2}
            if (csr_if.cr_lbe) m_pins = 4'hF;
            else m_pins = {~csr_if.cr_dtr, ~(csr_if.cr_rts & ~m_hold),
                           ~csr_if.cr_out1, ~csr_if.cr_out2};
        end
        #1;
        check("model_msr",   {24'd0, csr_if.msr}, {24'd0, m_st, m_dl});
        check("model_irq",   {31'd0, csr_if.msr_irq}, {31'd0, csr_if.cr_msien & (|m_dl)});
        check("model_pins",  {28'd0, dtr_no, rts_no, out1_no, out2_no}, {28'd0, m_pins});
        check("model_rx_en", {31'd0, rx_en}, {31'd0, m_rx_en});
        check("model_tx_en", {31'd0, tx_en}, {31'd0, m_tx_en});
    end

    // ---------------- stimulus ----------------
    task automatic randomize_cr();
        csr_if.cr_uarten = ($urandom_range(0, 7) != 0);
        csr_if.cr_rxe    = 1'($urandom_range(0, 1));
        csr_if.cr_txe    = 1'($urandom_range(0, 1));
        csr_if.cr_ctsen  = 1'($urandom_range(0, 1));
        csr_if.cr_rtsen  = 1'($urandom_range(0, 1));
        csr_if.cr_rts    = 1'($urandom_range(0, 1));
        csr_if.cr_dtr    = 1'($urandom_range(0, 1));
        csr_if.cr_out1   = 1'($urandom_range(0, 1));
        csr_if.cr_out2   = 1'($urandom_range(0, 1));
        csr_if.cr_lbe    = ($urandom_range(0, 5) == 0);
        csr_if.cr_msien  = 1'($urandom_range(0, 1));
    endtask

    task automatic pulse_msr_rd();
        csr_if.msr_rd = 1'b1;
        @(negedge clk);
        csr_if.msr_rd = 1'b0;
    endtask

    initial begin
        // 1: reset with random inputs
        rst_ni = 1'b0;
        randomize_cr();
        csr_if.cr_rxwm_hi = LVL_W'($urandom_range(0, FIFO_DEPTH));
        csr_if.cr_rxwm_lo = LVL_W'($urandom_range(0, FIFO_DEPTH));
        csr_if.msr_rd     = 1'($urandom_range(0, 1));
        rx_fifo_level     = LVL_W'($urandom_range(0, FIFO_DEPTH));
        tx_busy = 1'($urandom_range(0, 1));
        {ri_n, cts_n, dsr_n, dcd_n} = 4'($urandom_range(0, 15));
        repeat (3) @(negedge clk);
        check("rst_pins",  {28'd0, dtr_no, rts_no, out1_no, out2_no}, 32'hF);
        check("rst_msr",   {24'd0, csr_if.msr}, 32'h00);
        check("rst_irq",   {31'd0, csr_if.msr_irq}, 32'd0);
        check("rst_en",    {30'd0, rx_en, tx_en}, 32'd0);

        csr_if.cr_uarten = 1'b1; csr_if.cr_rxe = 1'b1; csr_if.cr_txe = 1'b1;
        csr_if.cr_ctsen = 1'b0; csr_if.cr_rtsen = 1'b0; csr_if.cr_rts = 1'b0;
        csr_if.cr_dtr = 1'b0; csr_if.cr_out1 = 1'b0; csr_if.cr_out2 = 1'b0;
        csr_if.cr_lbe = 1'b0; csr_if.cr_msien = 1'b1; csr_if.msr_rd = 1'b0;
        csr_if.cr_rxwm_hi = LVL_W'(24); csr_if.cr_rxwm_lo = LVL_W'(8);
        rx_fifo_level = '0; tx_busy = 1'b0;
        {ri_n, cts_n, dsr_n, dcd_n} = 4'hF;
        rst_ni = 1'b1;
        repeat (6) @(negedge clk);
        pulse_msr_rd();
        check("idle_msr", {24'd0, csr_if.msr}, 32'h00);

        // 2: CTS assertion latency and delta clear
        cts_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("cts_msr",  {24'd0, csr_if.msr}, 32'h11);
        check("cts_irq",  {31'd0, csr_if.msr_irq}, 32'd1);
        pulse_msr_rd();
        check("rd_msr",   {24'd0, csr_if.msr}, 32'h10);
        check("rd_irq",   {31'd0, csr_if.msr_irq}, 32'd0);

        // 3: auto-RTS hysteresis
        csr_if.cr_rtsen = 1'b1; csr_if.cr_rts = 1'b1;
        rx_fifo_level = LVL_W'(23);
        repeat (2) @(negedge clk);
        check("rts_23", {31'd0, rts_no}, 32'd0);
        rx_fifo_level = LVL_W'(24);
        @(negedge clk);
        check("rts_24", {31'd0, rts_no}, 32'd1);
        rx_fifo_level = LVL_W'(16);
        repeat (2) @(negedge clk);
        check("rts_16", {31'd0, rts_no}, 32'd1);
        rx_fifo_level = LVL_W'(8);
        @(negedge clk);
        check("rts_8",  {31'd0, rts_no}, 32'd0);

        // 4: auto-CTS waits for the frame to finish
        csr_if.cr_ctsen = 1'b1; tx_busy = 1'b1;
        @(negedge clk);
        check("cts_tx_on", {31'd0, tx_en}, 32'd1);
        cts_n = 1'b1;
        repeat (6) @(negedge clk);
        check("cts_mid_frame", {31'd0, tx_en}, 32'd1);
        tx_busy = 1'b0;
        @(negedge clk);
        check("cts_held", {31'd0, tx_en}, 32'd0);
        cts_n = 1'b0;
        repeat (5) @(negedge clk);
        check("cts_back", {31'd0, tx_en}, 32'd1);
        pulse_msr_rd();

        // 5: loopback routing and RI trailing edge
        csr_if.cr_lbe = 1'b1; csr_if.cr_out1 = 1'b1;
        repeat (2) @(negedge clk);
        csr_if.cr_out1 = 1'b0;
        repeat (2) @(negedge clk);
        check("lb_pins", {28'd0, dtr_no, rts_no, out1_no, out2_no}, 32'hF);
        check("lb_cts",  {31'd0, csr_if.msr[MSR_CTS]}, 32'd1);
        check("lb_teri", {31'd0, csr_if.msr[MSR_TERI]}, 32'd1);
        pulse_msr_rd();
        for (int i = 0; i < 6; i++) begin
            {ri_n, cts_n, dsr_n, dcd_n} = ~{ri_n, cts_n, dsr_n, dcd_n};
            @(negedge clk);
        end
        check("lb_pins_ignored", {24'd0, csr_if.msr}, 32'h10);

        // 6: delta set in the same cycle as a read survives
        csr_if.cr_out2 = 1'b1; csr_if.msr_rd = 1'b1;
        @(negedge clk);
        csr_if.msr_rd = 1'b0;
        check("ddcd_wins", {31'd0, csr_if.msr[MSR_DDCD]}, 32'd1);
        check("dcd_lb",    {31'd0, csr_if.msr[MSR_DCD]}, 32'd1);

        csr_if.cr_lbe = 1'b0;
        {ri_n, cts_n, dsr_n, dcd_n} = 4'hF;
        repeat (4) @(negedge clk);

        // Randomized phase, checked by the model every cycle.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (i == 1500) begin
                #2 rst_ni = 1'b0;
                #1;
                check("async_rst_pins", {28'd0, dtr_no, rts_no, out1_no, out2_no}, 32'hF);
                check("async_rst_msr",  {24'd0, csr_if.msr}, 32'h00);
                repeat (2) @(negedge clk);
                rst_ni = 1'b1;
            end
            if ($urandom_range(0, 15) == 0) randomize_cr();
            if ($urandom_range(0, 199) == 0) begin
                csr_if.cr_rxwm_hi = LVL_W'($urandom_range(0, FIFO_DEPTH));
                csr_if.cr_rxwm_lo = LVL_W'($urandom_range(0, FIFO_DEPTH));
            end
            if ($urandom_range(0, 7) == 0) ri_n  = ~ri_n;
            if ($urandom_range(0, 7) == 0) cts_n = ~cts_n;
            if ($urandom_range(0, 7) == 0) dsr_n = ~dsr_n;
            if ($urandom_range(0, 7) == 0) dcd_n = ~dcd_n;
            if ($urandom_range(0, 3) == 0)
                rx_fifo_level = LVL_W'($urandom_range(0, FIFO_DEPTH));
            else if ($urandom_range(0, 1) == 1 && rx_fifo_level < LVL_W'(FIFO_DEPTH))
                rx_fifo_level = rx_fifo_level + 1'b1;
            else if (rx_fifo_level > 0)
                rx_fifo_level = rx_fifo_level - 1'b1;
            if ($urandom_range(0, 5) == 0) tx_busy = ~tx_busy;
            csr_if.msr_rd = ($urandom_range(0, 9) == 0);
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
